// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SLT   = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_AL = 4'b0010,
        S_EXE_BR = 4'b0011,
        S_EXE_LS = 4'b0100,
        S_MEM    = 4'b0101,
        S_WB_AL  = 4'b0110,
        S_WB_LD  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    // Opcodes that take the EXE_AL -> WB_AL path.
    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLL, OP_SLTI, OP_SLT: is_alu_op = 1'b1;
            default:                          is_alu_op = 1'b0;
        endcase
    endfunction

    // R-type ALU ops write rd; the immediate forms write rt.
    function automatic logic is_rtype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT: is_rtype = 1'b1;
            default:                                is_rtype = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath: decoded-instruction
// inputs in, control strobes/selects and debug state out.
interface control_unit_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        sign;
    logic        PCWre, IRWre, RegWre, InsMemRW, mRD, mWR;
    logic        ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
    logic [2:0]  ALUOp;
    logic [1:0]  PCSrc;
    logic [1:0]  RegDst;
    logic [3:0]  state;
    logic [31:0] instr_cnt;

    modport master (
        input  opcode, zero, sign,
        output PCWre, IRWre, RegWre, InsMemRW, mRD, mWR,
        output ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
        output ALUOp, PCSrc, RegDst, state, instr_cnt
    );

    modport slave (
        output opcode, zero, sign,
        input  PCWre, IRWre, RegWre, InsMemRW, mRD, mWR,
        input  ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
        input  ALUOp, PCSrc, RegDst, state, instr_cnt
    );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational opcode decode for the shared ALU: operation, operand
// selects and immediate extension mode.
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [2:0] alu_op_o,
    output logic       alu_src_a_o,
    output logic       alu_src_b_o,
    output logic       ext_sel_o
);

    always_comb begin
        alu_op_o    = ALU_ADD;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        ext_sel_o   = 1'b1;
        case (opcode_i)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: alu_op_o = ALU_SUB;
            OP_ADDIU, OP_LW, OP_SW:          alu_src_b_o = 1'b1;
            OP_AND:                          alu_op_o = ALU_AND;
            OP_ANDI: begin
                alu_op_o    = ALU_AND;
                alu_src_b_o = 1'b1;
                ext_sel_o   = 1'b0;
            end
            OP_ORI: begin
                alu_op_o    = ALU_OR;
                alu_src_b_o = 1'b1;
                ext_sel_o   = 1'b0;
            end
            OP_XORI: begin
                alu_op_o    = ALU_XOR;
                alu_src_b_o = 1'b1;
                ext_sel_o   = 1'b0;
            end
            OP_SLL: begin
                alu_op_o    = ALU_SLL;
                alu_src_a_o = 1'b1;
            end
            OP_SLTI: begin
                alu_op_o    = ALU_SLT;
                alu_src_b_o = 1'b1;
            end
            OP_SLT:  alu_op_o = ALU_SLT;
            default: alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer (IF/ID/EXE/MEM/WB) with a retired
// instruction counter; control outputs decode combinationally from state.
module control_unit
    import ctrl_pkg::*;
(
    input  logic           CLK,
    input  logic           Reset,
    control_unit_if.master bus
);

    state_t      state_q, state_d;
    logic [31:0] cnt_q;

    logic [5:0] op;
    logic [2:0] dec_alu_op;
    logic       dec_src_a, dec_src_b, dec_ext;
    logic       pc_wre, ir_wre, reg_wre, ins_rd, m_rd, m_wr, db_src, wr_src;
    logic [1:0] pc_src, reg_dst;
    logic       hold_alu, taken;

    assign op = bus.opcode;

    alu_op_decoder u_alu_dec (
        .opcode_i    (op),
        .alu_op_o    (dec_alu_op),
        .alu_src_a_o (dec_src_a),
        .alu_src_b_o (dec_src_b),
        .ext_sel_o   (dec_ext)
    );

    always_comb begin
        case (op)
            OP_BEQ:  taken = bus.zero;
            OP_BNE:  taken = ~bus.zero;
            OP_BLTZ: taken = bus.sign;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                case (op)
                    OP_J, OP_JR, OP_JAL:     state_d = S_IF;
                    OP_BEQ, OP_BNE, OP_BLTZ: state_d = S_EXE_BR;
                    OP_SW, OP_LW:            state_d = S_EXE_LS;
                    OP_HALT:                 state_d = S_HALT;
                    default:                 state_d = is_alu_op(op) ? S_EXE_AL : S_IF;
                endcase
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = (op == OP_LW) ? S_WB_LD : S_IF;
            S_WB_AL:  state_d = S_IF;
            S_WB_LD:  state_d = S_IF;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IF;
        endcase
    end

    always_comb begin
        pc_wre  = 1'b0;
        ir_wre  = 1'b0;
        reg_wre = 1'b0;
        ins_rd  = 1'b0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        db_src  = 1'b0;
        wr_src  = 1'b0;
        pc_src  = PC_NEXT;
        reg_dst = RD_RA;
        case (state_q)
            S_IF: begin
                ir_wre = 1'b1;
                ins_rd = 1'b1;
            end
            S_ID: begin
                case (op)
                    OP_J: begin
                        pc_wre = 1'b1;
                        pc_src = PC_JUMP;
                    end
                    OP_JR: begin
                        pc_wre = 1'b1;
                        pc_src = PC_RS;
                    end
                    OP_JAL: begin
                        pc_wre  = 1'b1;
                        pc_src  = PC_JUMP;
                        reg_wre = 1'b1;
                    end
                    OP_BEQ, OP_BNE, OP_BLTZ, OP_SW, OP_LW, OP_HALT: pc_wre = 1'b0;
                    // Undefined opcodes retire here as a nop.
                    default: pc_wre = ~is_alu_op(op);
                endcase
            end
            S_EXE_BR: begin
                pc_wre = 1'b1;
                pc_src = taken ? PC_BRANCH : PC_NEXT;
            end
            S_MEM: begin
                if (op == OP_LW) begin
                    m_rd = 1'b1;
                end else begin
                    m_wr   = 1'b1;
                    pc_wre = 1'b1;
                end
            end
            S_WB_AL: begin
                reg_wre = 1'b1;
                wr_src  = 1'b1;
                pc_wre  = 1'b1;
                reg_dst = is_rtype(op) ? RD_RD : RD_RT;
            end
            S_WB_LD: begin
                m_rd    = 1'b1;
                db_src  = 1'b1;
                reg_wre = 1'b1;
                reg_dst = RD_RT;
                wr_src  = 1'b1;
                pc_wre  = 1'b1;
            end
            default: pc_wre = 1'b0;
        endcase
    end

    assign hold_alu = (state_q != S_IF) && (state_q != S_HALT);

    // Reset gates every strobe combinationally so nothing writes while it is low.
    assign bus.PCWre     = Reset & pc_wre;
    assign bus.IRWre     = Reset & ir_wre;
    assign bus.RegWre    = Reset & reg_wre;
    assign bus.InsMemRW  = ~Reset | ins_rd;
    assign bus.mRD       = Reset & m_rd;
    assign bus.mWR       = Reset & m_wr;
    assign bus.DBDataSrc = Reset & db_src;
    assign bus.WrRegDSrc = Reset & wr_src;
    assign bus.PCSrc     = Reset ? pc_src  : 2'b00;
    assign bus.RegDst    = Reset ? reg_dst : 2'b00;
    assign bus.ALUOp     = (Reset && hold_alu) ? dec_alu_op : 3'b000;
    assign bus.ALUSrcA   = Reset & hold_alu & dec_src_a;
    assign bus.ALUSrcB   = Reset & hold_alu & dec_src_b;
    assign bus.ExtSel    = Reset & hold_alu & dec_ext;
    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pc_wre) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the CPU datapath. It decodes the 6-bit opcode held in the instruction register and steps each instruction through IF/ID/EXE/MEM/WB states. It drives ALUSrcA, ALUSrcB and ALUOp for the shared ALU, plus all PC, IR, register-file, memory and mux selects. It also keeps a retired-instruction counter for debug.

## Interface
- No parameters.
- CLK  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low; forces state to IF.
- opcode  in  6  IR[31:26], valid from ID onward.
- zero  in  1  ALU zero flag.
- sign  in  1  ALU result[31].
- PCWre, IRWre, RegWre, InsMemRW, mRD, mWR  out  1 each  PC write, IR write, register write, instruction memory read, data memory read, data memory write.
- ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc  out  1 each  ALU A=sa; ALU B=ext imm; sign-extend; DB=mem; reg data=DB (0: PC+4).
- ALUOp  out  3  000 add, 001 sub, 010 signed lt, 011 unsigned lt, 100 sll, 101 or, 110 and, 111 xor.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump address.
- RegDst  out  2  00 $31, 01 rt, 10 rd.
- state  out  4  current state, for debug.
- instr_cnt  out  32  retired-instruction count.

## Operation
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slti 100110, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
- States: IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT.
- IF: IRWre=1, InsMemRW=1; next state ID.
- ID transitions:
  - j, jr, jal → IF, with PCWre=1 and PCSrc=11/10/11.
  - jal also asserts RegWre=1, RegDst=00, WrRegDSrc=0.
  - beq, bne, bltz → EXE_BR.
  - sw, lw → EXE_LS.
  - halt → HALT.
  - All other defined opcodes → EXE_AL.
  - Undefined opcodes → IF with PCWre=1, PCSrc=00 (treated as nop).
- EXE_AL → WB_AL → IF. WB_AL asserts RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00. RegDst=01 for I-type, 10 for R-type.
- EXE_BR → IF with PCWre=1. ALUOp=001, ALUSrcB=0. PCSrc=01 when taken, else 00.
  - beq taken if zero=1.
  - bne taken if zero=0.
  - bltz taken if sign=1.
- EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - sw → MEM. MEM asserts mWR=1, PCWre=1 → IF.
  - lw → MEM (mRD=1) → WB_LD. WB_LD asserts mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1, PCWre=1 → IF.
- ALU selects (held from ID through the last state of the instruction):
  - ALUSrcA=1 only for sll.
  - ALUSrcB=1 for addiu, andi, ori, xori, slti, lw, sw.
  - ExtSel=0 for andi, ori, xori; 1 otherwise.
  - ALUOp per opcode: add/addiu/lw/sw 000, sub/beq/bne/bltz 001, slt/slti 010, sll 100, ori 101, and/andi 110, xori 111.
- HALT: all write enables 0; remains in HALT until Reset.
- instr_cnt increments by 1 on every CLK edge where PCWre=1. It wraps from 0xFFFFFFFF to 0.

## Timing
- State register updates on the rising CLK edge. Outputs are combinational from state and opcode.
- Latency in cycles: j/jr/jal 2; branch 3; ALU ops 4; sw 4; lw 5.
- During Reset low: state=IF, instr_cnt=0.
- While Reset is low, PCWre, IRWre, RegWre, mWR and mRD are forced to 0. All selects and ALUOp read 0. InsMemRW reads 1.
- Reset mid-instruction aborts it immediately. No write enable is asserted after Reset falls.
- The first IF is the first rising edge after Reset rises.
- Write enables are asserted exactly one cycle per state. PC, register and memory writes commit on the edge that leaves that state.

## Structure
- ctrl_pkg holds:
  - opcode constants;
  - state encoding (IF=0000, ID=0001, EXE_AL=0010, EXE_BR=0011, EXE_LS=0100, MEM=0101, WB_AL=0110, WB_LD=0111, HALT=1000);
  - ALUOp, PCSrc and RegDst constants.
- Sub-module alu_op_decoder: combinational opcode → ALUOp, ALUSrcA, ALUSrcB, ExtSel. It is instantiated once inside control_unit.

## Test plan
- Reset low mid-EXE_AL → state=0000, instr_cnt=0, RegWre=0. After release, state goes IF→ID on successive edges.
- addiu (000010): 4 cycles. WB_AL shows RegWre=1, RegDst=01, ALUSrcB=1, ALUOp=000, ExtSel=1. instr_cnt 0→1.
- beq with zero=1 → EXE_BR gives PCSrc=01, PCWre=1. beq with zero=0 → PCSrc=00. bltz with sign=1 → PCSrc=01.
- lw (110001): 5 cycles; WB_LD shows DBDataSrc=1, RegWre=1, mRD=1. sw: MEM shows mWR=1, RegWre=0.
- jal (111010): 2 cycles. ID shows RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- halt (111111) → HALT persists for 100 cycles with PCWre=0 and instr_cnt unchanged. Undefined opcode 101010 → 2-cycle nop with PCSrc=00.
